// File: rtl/recv_q_if.sv
// Handshake bundle for recv_q: serial input controls and the assembled-word outputs.
// The overrun signal exists only when RECV_Q_OVERRUN_EN is defined.
interface recv_q_if #(
    parameter int WIDTH = 3
) ();
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic             serin;
    logic             shift_en;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             valid;
    logic [CW-1:0]    count;
`ifdef RECV_Q_OVERRUN_EN
    logic             overrun;

    modport master (
        output start, serin, shift_en, out_ready,
        input  q, busy, valid, count, overrun
    );
    modport slave (
        input  start, serin, shift_en, out_ready,
        output q, busy, valid, count, overrun
    );
`else
    modport master (
        output start, serin, shift_en, out_ready,
        input  q, busy, valid, count
    );
    modport slave (
        input  start, serin, shift_en, out_ready,
        output q, busy, valid, count
    );
`endif
endinterface

// File: rtl/recv_q.sv
// Serial-to-parallel word receiver (LSB first) with IDLE/COLLECT/FULL handshake.
// Optional sticky overrun flag enabled by defining RECV_Q_OVERRUN_EN.
module recv_q #(
    parameter int WIDTH = 3
) (
    input logic     clk,
    input logic     reset,
    recv_q_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
`ifdef RECV_Q_OVERRUN_EN
    logic             ov_q, ov_d;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
`ifdef RECV_Q_OVERRUN_EN
            ov_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
`ifdef RECV_Q_OVERRUN_EN
            ov_q    <= ov_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
`ifdef RECV_Q_OVERRUN_EN
        ov_d    = ov_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    q_d     = '0;
                    cnt_d   = '0;
`ifdef RECV_Q_OVERRUN_EN
                    ov_d    = 1'b0;
`endif
                end
            end
            COLLECT: begin
                // A restart takes priority over a bit arriving on the same edge.
                if (bus.start) begin
                    q_d   = '0;
                    cnt_d = '0;
`ifdef RECV_Q_OVERRUN_EN
                    ov_d  = 1'b0;
`endif
                end else if (bus.shift_en) begin
                    q_d   = {bus.serin, q_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    cnt_d = '0;
                    if (bus.start) begin
                        state_d = COLLECT;
                        q_d     = '0;
`ifdef RECV_Q_OVERRUN_EN
                        ov_d    = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
`ifdef RECV_Q_OVERRUN_EN
                    if (bus.shift_en) begin
                        ov_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                q_d     = '0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.q     = q_q;
    assign bus.count = cnt_q;
    assign bus.busy  = (state_q == COLLECT);
    assign bus.valid = (state_q == FULL);
`ifdef RECV_Q_OVERRUN_EN
    assign bus.overrun = ov_q;
`endif

endmodule

// File: tb/tb_recv_q.sv
// Scoreboard bench for recv_q: driver pushes expected post-edge state, monitor compares.
module tb_recv_q;
    localparam int W  = 3;
    localparam int CW = $clog2(W + 1);

    typedef struct packed {
        logic [W-1:0]  q;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          valid;
        logic          ov;
    } exp_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    exp_t exp_q[$];

    recv_q_if #(.WIDTH(W)) ifc ();

    recv_q #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: received bits held as a list, word built arithmetically.
    int   m_mode;   // 0 waiting, 1 collecting, 2 word complete
    bit   m_bits[$];
    logic [W-1:0] m_held;
    bit   m_ov;

    function automatic logic [W-1:0] word_of(input bit b[$]);
        logic [W-1:0] w;
        int n;
        w = '0;
        n = b.size();
        for (int i = 0; i < n; i++) begin
            if (b[i]) w[W - n + i] = 1'b1;
        end
        return w;
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        e.q     = (m_mode == 0) ? m_held : word_of(m_bits);
        e.cnt   = (m_mode == 0) ? '0 : CW'(m_bits.size());
        e.busy  = (m_mode == 1);
        e.valid = (m_mode == 2);
        e.ov    = m_ov;
        return e;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_bits.delete();
        m_held = '0;
        m_ov   = 1'b0;
    endtask

    task automatic model_step(input bit st, input bit sh, input bit si, input bit rdy);
        if (m_mode == 0) begin
            if (st) begin
                m_mode = 1; m_bits.delete(); m_ov = 1'b0;
            end
        end else if (m_mode == 1) begin
            if (st) begin
                m_bits.delete(); m_ov = 1'b0;
            end else if (sh) begin
                m_bits.push_back(si);
                if (m_bits.size() == W) m_mode = 2;
            end
        end else begin
            if (rdy && st) begin
                m_mode = 1; m_bits.delete(); m_ov = 1'b0;
            end else if (rdy) begin
                m_held = word_of(m_bits); m_mode = 0; m_bits.delete();
            end else if (sh) begin
                m_ov = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock of stimulus, optionally with an asynchronous reset pulse mid-cycle.
    task automatic cycle(input bit st, input bit sh, input bit si, input bit rdy, input bit rp);
        @(negedge clk);
        if (rp) begin
            reset = 1'b0;
            #1;
            chk("rst_q",     32'(ifc.q), 0);
            chk("rst_count", 32'(ifc.count), 0);
            chk("rst_busy",  32'(ifc.busy), 0);
            chk("rst_valid", 32'(ifc.valid), 0);
`ifdef RECV_Q_OVERRUN_EN
            chk("rst_ovr",   32'(ifc.overrun), 0);
`endif
            reset = 1'b1;
            model_reset();
        end
        ifc.start     = st;
        ifc.shift_en  = sh;
        ifc.serin     = si;
        ifc.out_ready = rdy;
        model_step(st, sh, si, rdy);
        exp_q.push_back(model_view());
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q",     32'(ifc.q), 32'(e.q));
            chk("count", 32'(ifc.count), 32'(e.cnt));
            chk("busy",  32'(ifc.busy), 32'(e.busy));
            chk("valid", 32'(ifc.valid), 32'(e.valid));
`ifdef RECV_Q_OVERRUN_EN
            chk("overrun", 32'(ifc.overrun), 32'(e.ov));
`endif
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        ifc.start = 1'b0; ifc.shift_en = 1'b0; ifc.serin = 1'b0; ifc.out_ready = 1'b0;
        model_reset();
        #2;
        chk("init_q",     32'(ifc.q), 0);
        chk("init_count", 32'(ifc.count), 0);
        chk("init_busy",  32'(ifc.busy), 0);
        chk("init_valid", 32'(ifc.valid), 0);
        #5 reset = 1'b1;

        // Word 1,0,1 on consecutive edges, then accept.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // Word 0,1,1 with gaps, then held in FULL under pressure.
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // Accept and restart on the same edge.
        cycle(1, 0, 0, 1, 0);
        // Restart at count 2 beats a simultaneous bit.
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(1, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 0);
        // Reset mid-word after two bits; no valid afterwards.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 1, 0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 59) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/recv_q.md
RECV_Q -- requirements
Module: recv_q

Interface
REQ-001 Parameter: WIDTH, 3, number of serial bits assembled per word (>=2).
REQ-002 Port: clk  in  1  rising-edge clock, sole clock domain.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  clears register and counter, begins a new word.
REQ-005 Port: serin  in  1  serial data bit, LSB first (the LSB of a right-shifting Q register).
REQ-006 Port: shift_en  in  1  qualifies serin; one bit captured per cycle when high.
REQ-007 Port: out_ready  in  1  consumer accepts the assembled word.
REQ-008 Port: q  out  WIDTH  assembled parallel word.
REQ-009 Port: busy  out  1  high in COLLECT.
REQ-010 Port: valid  out  1  high in FULL; q is stable and complete.
REQ-011 Port: count  out  clog2(WIDTH+1)  bits captured so far in the current word.

Function
REQ-012 FSM states SHALL be IDLE, COLLECT and FULL; busy=(state==COLLECT) and valid=(state==FULL), both registered.
REQ-013 IDLE: start -> COLLECT with q=0 and count=0 on the same edge; shift_en is ignored.
REQ-014 COLLECT, shift_en=1: q <= {serin, q[WIDTH-1:1]}; count increments; serin enters the MSB, so the first bit received ends in q[0].
REQ-015 COLLECT: the shift that makes count==WIDTH SHALL also move to FULL, so valid rises on that same edge (zero-cycle latency after the last bit).
REQ-016 COLLECT, shift_en=0: q and count hold.
REQ-017 COLLECT, start=1: restart; q=0 and count=0, state stays COLLECT, and start wins over a simultaneous shift_en.
REQ-018 FULL: q and count hold and shift_en is ignored; out_ready=1 -> IDLE, with q retaining the word and count reset to 0.
REQ-019 FULL, start=1 and out_ready=1 together: the word is accepted and the edge goes directly to COLLECT with q=0 and count=0.
REQ-020 FULL, start=1 and out_ready=0: start is ignored and the word is not lost.
REQ-021 IDLE: out_ready has no effect.
REQ-022 Count SHALL never exceed WIDTH, and there is no wrap-around.

Reset
REQ-023 reset=0 SHALL immediately force state=IDLE, q=0, count=0, busy=0 and valid=0, independent of clk.
REQ-024 Reset asserted mid-word SHALL discard the partial word, and no valid pulse follows.
REQ-025 After reset deasserts, the first start is honoured on the next rising edge.

Configuration
REQ-026 Macro RECV_Q_OVERRUN_EN SHALL control the overrun feature.
REQ-027 With RECV_Q_OVERRUN_EN defined: output port overrun (1 bit) is sticky and set when shift_en=1 in FULL without out_ready=1; it is cleared by reset or an accepted start; q is unaffected.
REQ-028 Without RECV_Q_OVERRUN_EN: the overrun port does not exist, and shift_en in FULL is silently ignored.

Verification (WIDTH=3)
REQ-029 Scenario 1: reset, start, then shift_en with serin 1,0,1 on 3 consecutive edges -> valid rises on the 3rd edge, q=3'b101, count=3, busy=0.
REQ-030 Scenario 2: start, serin 0,1,1 with shift_en low for 2 cycles between bits -> q=3'b110 and valid only after the 3rd qualified bit.
REQ-031 Scenario 3: FULL with q=3'b110 for 4 cycles with out_ready=0 and shift_en=1, serin=1 -> q stays 3'b110; overrun=1 when the macro is defined.
REQ-032 Scenario 4: FULL, start=1 and out_ready=1 on the same edge -> busy=1, valid=0, q=0, count=0 next cycle.
REQ-033 Scenario 5: reset pulsed low between clock edges after 2 bits captured -> q=0, count=0, IDLE immediately, and no valid afterwards.
REQ-034 Scenario 6: start asserted together with shift_en, serin=1 in COLLECT at count=2 -> count=0, q=0, valid stays 0.
